// File: rtl/score_keeper_pkg.sv
// Shared game definitions: state encodings, default column count and a popcount helper.
package score_keeper_pkg;

  localparam int unsigned NUM_COLS_DEF = 4;
  localparam int unsigned CNT_W        = 6;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_PLAYING   = 2'b01,
    ST_GAME_OVER = 2'b10
  } game_state_e;

  // Callers zero-extend their vector to 32 bits.
  function automatic logic [CNT_W-1:0] popcount(input logic [31:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/score_keeper_combo_mult.sv
// Combo counter with saturation and the multiplier derived from the post-update combo.
module score_keeper_combo_mult
  import score_keeper_pkg::*;
#(
  parameter int unsigned COMBO_STEP = 8,
  parameter int unsigned MAX_MULT   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  input  logic             miss_any,
  input  logic [CNT_W-1:0] nh,
  output logic [7:0]       combo,
  output logic [2:0]       multiplier
);

  logic [7:0]  combo_q, combo_d;
  logic [2:0]  mult_q, mult_d;
  logic [8:0]  sum_c;
  logic [31:0] step_c;

  always_comb begin
    combo_d = combo_q;
    mult_d  = mult_q;
    sum_c   = 9'(combo_q) + 9'(nh);
    step_c  = '0;
    if (clear) begin
      combo_d = 8'd0;
      mult_d  = 3'd1;
    end else if (en) begin
      if (miss_any) begin
        combo_d = 8'd0;
      end else begin
        combo_d = sum_c[8] ? 8'd255 : sum_c[7:0];
      end
      // Multiplier follows the new combo so a completed step takes effect next cycle.
      step_c = 32'(combo_d) / COMBO_STEP + 32'd1;
      mult_d = (step_c > MAX_MULT) ? 3'(MAX_MULT) : 3'(step_c);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      combo_q <= 8'd0;
      mult_q  <= 3'd1;
    end else begin
      combo_q <= combo_d;
      mult_q  <= mult_d;
    end
  end

  assign combo      = combo_q;
  assign multiplier = mult_q;

endmodule

// File: rtl/score_keeper.sv
// Game-level state machine: score with combo multiplier, lives, and high score across games.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int unsigned NUM_COLS    = NUM_COLS_DEF,
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned SCORE_W     = 16,
  parameter int unsigned BASE_POINTS = 1,
  parameter int unsigned COMBO_STEP  = 8,
  parameter int unsigned MAX_MULT    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                frame_tick,
  input  logic                start,
  input  logic [NUM_COLS-1:0] hit,
  input  logic [NUM_COLS-1:0] miss,
  output logic [SCORE_W-1:0]  score,
  output logic [SCORE_W-1:0]  high_score,
  output logic [7:0]          combo,
  output logic [2:0]          multiplier,
  output logic [3:0]          lives,
  output logic [1:0]          game_state,
  output logic                playing
);

  localparam int unsigned SUM_W = SCORE_W + 16;

  game_state_e         state_q, state_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [SCORE_W-1:0]  high_q, high_d;
  logic [3:0]          lives_q, lives_d;
  logic [NUM_COLS-1:0] hit_d_q;
  logic                playing_q, playing_d;

  logic [NUM_COLS-1:0] new_hits_c;
  logic [CNT_W-1:0]    nh_c, nm_c;
  logic [15:0]         points_c;
  logic [SUM_W-1:0]    sum_c;
  logic [SCORE_W-1:0]  score_sat_c;
  logic [3:0]          lives_nx_c;
  logic                load_c;
  logic [2:0]          mult_c;

  // Rising-edge detect on hits; misses only count on frame ticks.
  assign new_hits_c  = hit & ~hit_d_q;
  assign nh_c        = popcount(32'(new_hits_c));
  assign nm_c        = frame_tick ? popcount(32'(miss)) : '0;
  assign points_c    = 16'(nh_c) * 16'(BASE_POINTS) * 16'(mult_c);
  assign sum_c       = SUM_W'(score_q) + SUM_W'(points_c);
  assign score_sat_c = (|sum_c[SUM_W-1:SCORE_W]) ? '1 : sum_c[SCORE_W-1:0];
  assign lives_nx_c  = (CNT_W'(lives_q) <= nm_c) ? 4'd0 : lives_q - 4'(nm_c);

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    high_d  = high_q;
    lives_d = lives_q;
    load_c  = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start) begin
          state_d = ST_PLAYING;
          load_c  = 1'b1;
          score_d = '0;
          lives_d = 4'(START_LIVES);
        end
      end
      ST_PLAYING: begin
        score_d = score_sat_c;
        lives_d = lives_nx_c;
        if (lives_nx_c == 4'd0) begin
          state_d = ST_GAME_OVER;
          if (score_sat_c > high_q) high_d = score_sat_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    playing_d = (state_d == ST_PLAYING);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      score_q   <= '0;
      high_q    <= '0;
      lives_q   <= 4'(START_LIVES);
      hit_d_q   <= '0;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      high_q    <= high_d;
      lives_q   <= lives_d;
      hit_d_q   <= hit;
      playing_q <= playing_d;
    end
  end

  score_keeper_combo_mult #(
    .COMBO_STEP(COMBO_STEP),
    .MAX_MULT  (MAX_MULT)
  ) u_combo_mult (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (load_c),
    .en        (state_q == ST_PLAYING),
    .miss_any  (nm_c != '0),
    .nh        (nh_c),
    .combo     (combo),
    .multiplier(mult_c)
  );

  assign score      = score_q;
  assign high_score = high_q;
  assign multiplier = mult_c;
  assign lives      = lives_q;
  assign game_state = state_q;
  assign playing    = playing_q;

endmodule
